// File: rtl/dt_pkg.sv
// Shared types and constants for the distance-transform sequencer.
// The optional cycle counter in dt_ctrl is enabled with DT_PERF_CNT_EN.
package dt_pkg;

  localparam int STI_AW    = 10;
  localparam int STI_DW    = 16;
  localparam int RES_AW    = 14;
  localparam int PIX_W     = 8;
  localparam int IMG_W     = 128;
  localparam int IMG_PIX   = 16384;
  localparam int STI_WORDS = 1024;
  localparam int CYC_W     = 20;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FWD,
    BWD,
    DONE
  } dt_state_e;

endpackage

// File: rtl/dt_sti_loader.sv
// Unpacks 1-bit-per-pixel sti words into a stream of res pixel writes,
// prefetching the next word while the last pixel of the current one is written.
module dt_sti_loader
  import dt_pkg::*;
#(
  parameter int P_STI_AW = STI_AW,
  parameter int P_STI_DW = STI_DW,
  parameter int P_RES_AW = RES_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_en,
  input  logic [P_STI_DW-1:0] sti_di,
  output logic                sti_rd,
  output logic [P_STI_AW-1:0] sti_addr,
  output logic                load_wr,
  output logic [P_RES_AW-1:0] load_addr,
  output logic                load_bit,
  output logic                load_done
);

  localparam int SH = $clog2(P_STI_DW);

  logic                r_fetched;
  logic [P_RES_AW-1:0] r_pix;
  logic [P_STI_DW-1:0] r_shift;

  logic [P_STI_AW-1:0] w_word;
  logic [SH-1:0]       w_sub;
  logic                w_first;
  logic                w_prefetch;
  logic [P_STI_DW-1:0] w_src;

  assign w_word  = r_pix[P_RES_AW-1:SH];
  assign w_sub   = r_pix[SH-1:0];
  assign w_first = (w_sub == '0);
  // Pixel 0 of a word comes straight off sti_di; the rest from the shifter.
  assign w_src   = w_first ? sti_di : r_shift;

  assign load_wr    = load_en & r_fetched;
  assign load_addr  = r_pix;
  assign load_bit   = w_src[P_STI_DW-1];
  assign w_prefetch = load_wr & (&w_sub) & ~(&w_word);
  assign sti_rd     = (load_en & ~r_fetched) | w_prefetch;
  assign sti_addr   = w_prefetch ? (w_word + 1'b1) : '0;
  assign load_done  = load_wr & (&r_pix);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples the pre-edge values.
    if (!reset || !load_en) begin
      r_fetched <= 1'b0;
      r_pix     <= '0;
      r_shift   <= '0;
    end else if (!r_fetched) begin
      r_fetched <= 1'b1;
    end else begin
      r_shift <= {w_src[P_STI_DW-2:0], 1'b0};
      if (!(&r_pix)) r_pix <= r_pix + 1'b1;
    end
  end

endmodule

// File: rtl/dt_ctrl.sv
// Distance-transform top sequencer: load sti into res, run forward then backward
// engines, then hold done. Define DT_PERF_CNT_EN to add the cyc_cnt output.
module dt_ctrl
  import dt_pkg::*;
#(
  parameter int P_STI_AW = STI_AW,
  parameter int P_STI_DW = STI_DW,
  parameter int P_RES_AW = RES_AW,
  parameter int P_PIX_W  = PIX_W
) (
  input  logic                clk,
  input  logic                reset,
  output logic                sti_rd,
  output logic [P_STI_AW-1:0] sti_addr,
  input  logic [P_STI_DW-1:0] sti_di,
  output logic                res_rd,
  output logic                res_wr,
  output logic [P_RES_AW-1:0] res_addr,
  output logic [P_PIX_W-1:0]  res_do,
  output logic                done,
  output logic                for_load_en,
  output logic                for_en,
  input  logic                for_load_done,
  input  logic                for_done,
  input  logic                for_op_done,
  input  logic [P_RES_AW-1:0] res_addr_for,
  input  logic [P_PIX_W-1:0]  res_do_for,
  output logic                back_load_en,
  output logic                back_en,
  input  logic                back_load_done,
  input  logic                back_done,
  input  logic                back_op_done,
  input  logic [P_RES_AW-1:0] res_addr_back,
  input  logic [P_PIX_W-1:0]  res_do_back
`ifdef DT_PERF_CNT_EN
  ,
  output logic [CYC_W-1:0]    cyc_cnt
`endif
);

  dt_state_e r_state, w_next;

  logic                w_load_en;
  logic                w_load_wr;
  logic [P_RES_AW-1:0] w_load_addr;
  logic                w_load_bit;
  logic                w_load_done;
  logic                w_unused;

  // The engines report load completion to themselves; the sequencer only needs op_done.
  assign w_unused  = ^{for_load_done, back_load_done};
  assign w_load_en = (r_state == LOAD);

  dt_sti_loader #(
    .P_STI_AW(P_STI_AW),
    .P_STI_DW(P_STI_DW),
    .P_RES_AW(P_RES_AW)
  ) u_loader (
    .clk      (clk),
    .reset    (reset),
    .load_en  (w_load_en),
    .sti_di   (sti_di),
    .sti_rd   (sti_rd),
    .sti_addr (sti_addr),
    .load_wr  (w_load_wr),
    .load_addr(w_load_addr),
    .load_bit (w_load_bit),
    .load_done(w_load_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    w_next       = r_state;
    res_rd       = 1'b0;
    res_wr       = 1'b0;
    res_addr     = '0;
    res_do       = '0;
    done         = 1'b0;
    for_load_en  = 1'b0;
    for_en       = 1'b0;
    back_load_en = 1'b0;
    back_en      = 1'b0;
    unique case (r_state)
      IDLE: w_next = LOAD;
      LOAD: begin
        res_wr   = w_load_wr;
        res_addr = w_load_addr;
        res_do   = w_load_wr ? P_PIX_W'(w_load_bit) : '0;
        if (w_load_done) w_next = FWD;
      end
      FWD: begin
        for_load_en = 1'b1;
        for_en      = 1'b1;
        res_addr    = res_addr_for;
        res_do      = res_do_for;
        res_wr      = for_done;
        res_rd      = ~for_done;
        if (for_op_done) w_next = BWD;
      end
      BWD: begin
        back_load_en = 1'b1;
        back_en      = 1'b1;
        res_addr     = res_addr_back;
        res_do       = res_do_back;
        res_wr       = back_done;
        res_rd       = ~back_done;
        if (back_op_done) w_next = DONE;
      end
      DONE: done = 1'b1;
      default: w_next = IDLE;
    endcase
  end

`ifdef DT_PERF_CNT_EN
  logic [CYC_W-1:0] r_cyc_cnt;
  logic             w_busy;

  assign w_busy  = (r_state == LOAD) || (r_state == FWD) || (r_state == BWD);
  assign cyc_cnt = r_cyc_cnt;

  always_ff @(posedge clk) begin
    if (!reset)                      r_cyc_cnt <= '0;
    else if (w_busy && !(&r_cyc_cnt)) r_cyc_cnt <= r_cyc_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_dt_ctrl.sv
// Self-checking bench for dt_ctrl: sti ROM model, image reference, engine stubs.
module tb_dt_ctrl;

  localparam int NPIX   = 16384;
  localparam int NWORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        sti_rd;
  logic [9:0]  sti_addr;
  logic [15:0] sti_di = '0;
  logic        res_rd, res_wr, done;
  logic [13:0] res_addr;
  logic [7:0]  res_do;
  logic        for_load_en, for_en, back_load_en, back_en;
  logic        for_load_done, for_done, for_op_done;
  logic        back_load_done, back_done, back_op_done;
  logic [13:0] res_addr_for, res_addr_back;
  logic [7:0]  res_do_for, res_do_back;
`ifdef DT_PERF_CNT_EN
  logic [19:0] cyc_cnt;
`endif

  logic [15:0] rom [NWORDS];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (sti_rd) sti_di <= rom[sti_addr];

  dt_ctrl dut (
    .clk(clk), .reset(reset),
    .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
    .done(done),
    .for_load_en(for_load_en), .for_en(for_en),
    .for_load_done(for_load_done), .for_done(for_done), .for_op_done(for_op_done),
    .res_addr_for(res_addr_for), .res_do_for(res_do_for),
    .back_load_en(back_load_en), .back_en(back_en),
    .back_load_done(back_load_done), .back_done(back_done), .back_op_done(back_op_done),
    .res_addr_back(res_addr_back), .res_do_back(res_do_back)
`ifdef DT_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_engines();
    for_load_done = 0; for_done = 0; for_op_done = 0; res_addr_for = '0; res_do_for = '0;
    back_load_done = 0; back_done = 0; back_op_done = 0; res_addr_back = '0; res_do_back = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {sti_rd, sti_addr, res_rd, res_wr, done,
                          for_load_en, for_en, back_load_en, back_en}, 32'd0);
    check({tag, "_bus"}, {res_addr, res_do}, 32'd0);
`ifdef DT_PERF_CNT_EN
    check({tag, "_cnt"}, cyc_cnt, 32'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_engines();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_idle("rst");
    reset = 1'b1;
    #1;
    check_idle("idle");
  endtask

  // Expected LOAD behaviour: one fetch cycle, then pixel p written at cycle p+1.
  task automatic load_phase();
    int rd_cnt, bad_seq, bad_data, bad_addr;
    logic [15:0] w;
    logic eb;
    @(negedge clk); #1;
    check("ld_fetch0", {sti_rd, sti_addr, res_wr, res_rd}, {1'b1, 10'd0, 1'b0, 1'b0});
    rd_cnt = 1; bad_seq = 0; bad_data = 0; bad_addr = 0;
    for (int p = 0; p < NPIX; p++) begin
      @(negedge clk); #1;
      w  = rom[p / 16];
      eb = w[15 - (p % 16)];
      if (p == 0) check("ld_first", {res_wr, res_addr, res_do}, {1'b1, 14'd0, 7'd0, eb});
      if (p == NPIX - 1) check("ld_last", {res_wr, res_addr}, {1'b1, 14'd16383});
      if (!(res_wr === 1'b1 && res_rd === 1'b0 && res_addr === 14'(p) &&
            for_en === 1'b0 && done === 1'b0)) bad_seq++;
      if (res_do !== {7'd0, eb}) bad_data++;
      if (sti_rd === 1'b1) begin
        if (sti_addr !== 10'(rd_cnt)) bad_addr++;
        rd_cnt++;
      end
    end
    check("ld_seq", bad_seq, 0);
    check("ld_data", bad_data, 0);
    check("ld_sti_addr", bad_addr, 0);
    check("ld_sti_rd_cnt", rd_cnt, NWORDS);
  endtask

  // Engine stub: write strobe every `period` cycles, op_done from cycle n_op on.
  task automatic engine_phase(input bit back, input int n_op, input int period,
                              input int abort_at, output bit aborted);
    int bad, writes, exp_writes;
    logic dn, op;
    logic [13:0] a;
    logic [7:0] d;
    logic [3:0] en_exp;
    string tag;
    tag = back ? "bwd" : "fwd";
    en_exp = back ? 4'b0011 : 4'b1100;
    bad = 0; writes = 0; exp_writes = 0; aborted = 1'b0;
    for (int c = 0; c <= n_op; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        aborted = 1'b1;
        return;
      end
      dn = ((c % period) == period - 1);
      op = (c >= n_op);
      a  = 14'($urandom_range(0, NPIX - 1));
      d  = 8'($urandom_range(0, 255));
      if (!back) begin
        for_done = dn; for_op_done = op; res_addr_for = a; res_do_for = d; for_load_done = (c > 0);
      end else begin
        back_done = dn; back_op_done = op; res_addr_back = a; res_do_back = d; back_load_done = (c > 0);
      end
      #1;
      if (c == 0) check({tag, "_enable"}, {for_load_en, for_en, back_load_en, back_en}, en_exp);
      if ({for_load_en, for_en, back_load_en, back_en} !== en_exp) bad++;
      if (res_wr !== dn || res_rd !== ~dn || res_addr !== a || res_do !== d ||
          sti_rd !== 1'b0 || done !== 1'b0) bad++;
      if (dn) exp_writes++;
      if (res_wr === 1'b1) writes++;
      if (op) check({tag, "_opdone_wr"}, {res_wr, res_rd}, {dn, ~dn});
    end
    check({tag, "_mux"}, bad, 0);
    check({tag, "_writes"}, writes, exp_writes);
  endtask

  task automatic done_phase(input int exp_cnt);
    int bad;
    @(negedge clk); #1;
    check("done_rise", {done, for_load_en, for_en, back_load_en, back_en, res_wr, res_rd, sti_rd},
          {1'b1, 7'd0});
    check("done_addr", res_addr, 0);
`ifdef DT_PERF_CNT_EN
    check("cyc_cnt", cyc_cnt, exp_cnt);
`endif
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (done !== 1'b1 || res_wr !== 1'b0 || res_rd !== 1'b0 || sti_rd !== 1'b0) bad++;
    end
    check("done_hold", bad, 0);
`ifdef DT_PERF_CNT_EN
    check("cyc_cnt_frozen", cyc_cnt, exp_cnt);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ab;
    // Run 1: all-ones image, simple engine timing.
    for (int i = 0; i < NWORDS; i++) rom[i] = 16'hFFFF;
    do_reset();
    load_phase();
    engine_phase(1'b0, 30, 6, -1, ab);
    engine_phase(1'b1, 23, 4, -1, ab);
    done_phase(16385 + 31 + 24);

    // Run 2: random image with a marker word, reset mid-FWD, then a full pass.
    rom[0] = 16'h8001;
    for (int i = 1; i < NWORDS; i++) rom[i] = 16'($urandom);
    do_reset();
    load_phase();
    engine_phase(1'b0, 1000, 6, 50, ab);
    check("abort_reached", ab, 1);
    reset = 1'b0;
    clear_engines();
    @(negedge clk); #1;
    check_idle("mid_rst");
    reset = 1'b1;
    load_phase();
    engine_phase(1'b0, 47, 6, -1, ab);
    engine_phase(1'b1, 99, 5, -1, ab);
    done_phase(16385 + 48 + 100);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
